// File: rtl/prog_timeout_timer.sv
// Programmable countdown timer: LOAD ticks of CLK_PER_TICK clocks, one-shot or periodic.
// Optional warn output is built only when the TIMER_WARN_EN macro is defined.
module prog_timeout_timer #(
  parameter int unsigned CLK_PER_TICK = 100000,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned PRE_W        = 17,
  parameter int unsigned WARN_TICKS   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic             abort,
  input  logic             periodic,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick,
  output logic             timeout,
  output logic             busy,
`ifdef TIMER_WARN_EN
  output logic             warn,
`endif
  output logic [CNT_W-1:0] remaining
);

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_PER_TICK - 1);

  // Reject configurations where the prescaler cannot reach its wrap value.
  if ((CLK_PER_TICK < 2) || ((64'd1 << PRE_W) < 64'(CLK_PER_TICK)) ||
      (64'(WARN_TICKS) >= (64'd1 << CNT_W))) begin : g_bad_cfg
    $error("prog_timeout_timer: invalid parameter set");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic             per_q, per_d;
  logic             tick_q, tick_d;
  logic             timeout_q, timeout_d;
  logic             wrap_s;
  logic             expire_s;

  // Next-state and output decode; abort outranks start, start outranks counting.
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    rem_d     = rem_q;
    reload_d  = reload_q;
    per_d     = per_q;
    tick_d    = 1'b0;
    timeout_d = 1'b0;
    wrap_s    = (state_q == RUN) && enable && (pre_q == PRE_MAX);
    expire_s  = wrap_s && (rem_q == CNT_W'(1));

    if (abort) begin
      state_d = IDLE;
      pre_d   = {PRE_W{1'b0}};
      rem_d   = {CNT_W{1'b0}};
    end else if (start) begin
      // A one-shot expiry still reports when restarted; a periodic one is swallowed.
      tick_d    = wrap_s;
      timeout_d = (expire_s && !per_q) || (load_val == {CNT_W{1'b0}});
      reload_d  = load_val;
      per_d     = periodic;
      pre_d     = {PRE_W{1'b0}};
      if (load_val == {CNT_W{1'b0}}) begin
        state_d = IDLE;
        rem_d   = {CNT_W{1'b0}};
      end else begin
        state_d = RUN;
        rem_d   = load_val;
      end
    end else if (wrap_s) begin
      tick_d = 1'b1;
      pre_d  = {PRE_W{1'b0}};
      if (rem_q == CNT_W'(1)) begin
        timeout_d = 1'b1;
        if (per_q) begin
          rem_d = reload_q;
        end else begin
          state_d = IDLE;
          rem_d   = {CNT_W{1'b0}};
        end
      end else if (rem_q == {CNT_W{1'b0}}) begin
        rem_d = {CNT_W{1'b0}};
      end else begin
        rem_d = rem_q - CNT_W'(1);
      end
    end else if ((state_q == RUN) && enable) begin
      pre_d = pre_q + PRE_W'(1);
    end else begin
      pre_d = pre_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pre_q     <= {PRE_W{1'b0}};
      rem_q     <= {CNT_W{1'b0}};
      reload_q  <= {CNT_W{1'b0}};
      per_q     <= 1'b0;
      tick_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      rem_q     <= rem_d;
      reload_q  <= reload_d;
      per_q     <= per_d;
      tick_q    <= tick_d;
      timeout_q <= timeout_d;
    end
  end

  assign tick      = tick_q;
  assign timeout   = timeout_q;
  assign busy      = (state_q == RUN);
  assign remaining = rem_q;

`ifdef TIMER_WARN_EN
  logic warn_q, warn_d;

  always_comb begin
    warn_d = (state_d == RUN) && (rem_d <= CNT_W'(WARN_TICKS));
  end

  // Warn flag follows the next remaining count so it rises on the crossing edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign warn = warn_q;
`endif

endmodule

// File: tb/tb_prog_timeout_timer.sv
// Self-checking bench for prog_timeout_timer: directed table, spec sequences and a
// randomized run against an elapsed-clock arithmetic model.
module tb_prog_timeout_timer;
  localparam int CPT  = 4;
  localparam int WARN = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0, start = 1'b0, abort = 1'b0, periodic = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic       tick, timeout, busy;
  logic [7:0] remaining;
`ifdef TIMER_WARN_EN
  logic       warn;
`endif

  prog_timeout_timer #(.CLK_PER_TICK(CPT), .CNT_W(8), .PRE_W(3), .WARN_TICKS(WARN)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .abort(abort),
    .periodic(periodic), .load_val(load_val), .tick(tick), .timeout(timeout),
`ifdef TIMER_WARN_EN
    .warn(warn),
`endif
    .busy(busy), .remaining(remaining)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: count enabled clocks since the run (or last reload) began.
  bit m_run = 1'b0, m_per = 1'b0;
  int m_reload = 0, m_el = 0;
  bit exp_tick = 1'b0, exp_to = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int m_rem();
    return m_run ? (m_reload - m_el / CPT) : 0;
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_per = 1'b0; m_reload = 0; m_el = 0;
    exp_tick = 1'b0; exp_to = 1'b0;
  endtask

  task automatic model_edge(input bit e, input bit s, input bit a, input bit p, input int l);
    bit wrap;
    wrap = m_run && e && (((m_el + 1) % CPT) == 0);
    exp_tick = 1'b0;
    exp_to   = 1'b0;
    if (a) begin
      m_run = 1'b0;
    end else if (s) begin
      exp_tick = wrap;
      exp_to   = (l == 0) || (wrap && !m_per && ((m_el + 1) / CPT == m_reload));
      m_reload = l; m_per = p; m_el = 0; m_run = (l != 0);
    end else if (m_run && e) begin
      m_el++;
      if (m_el % CPT == 0) begin
        exp_tick = 1'b1;
        if (m_el / CPT == m_reload) begin
          exp_to = 1'b1;
          if (m_per) m_el = 0;
          else m_run = 1'b0;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("tick", tick, exp_tick);
    chk("timeout", timeout, exp_to);
    chk("busy", busy, m_run);
    chk("remaining", remaining, m_rem());
`ifdef TIMER_WARN_EN
    chk("warn", warn, m_run && (m_rem() <= WARN));
`endif
  endtask

  task automatic step(input bit e, input bit s, input bit a, input bit p, input int l);
    @(negedge clk);
    enable = e; start = s; abort = a; periodic = p; load_val = 8'(l);
    @(posedge clk);
    cyc++;
    model_edge(e, s, a, p, l);
    #1;
    check_model();
  endtask

  typedef struct {
    bit en, st, ab, per;
    int ld;
    bit tk, to, bz;
    int rm;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(bit en, bit st, bit ab, bit per, int ld,
                              bit tk, bit to, bit bz, int rm);
    vec_t v;
    v.en = en; v.st = st; v.ab = ab; v.per = per; v.ld = ld;
    v.tk = tk; v.to = to; v.bz = bz; v.rm = rm;
    return v;
  endfunction

  int k, t_first, t_cnt, to_off[$], tk_off[$], w_first, w_at12;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rem", remaining, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_tick", tick, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Directed table: zero-length run, start+abort, pause at expiry, restarts.
    vq.push_back(mk(1,1,0,0,0, 0,1,0,0));
    vq.push_back(mk(1,0,0,0,0, 0,0,0,0));
    vq.push_back(mk(1,1,1,0,5, 0,0,0,0));
    vq.push_back(mk(1,1,0,0,2, 0,0,1,2));
    for (int i = 0; i < 3; i++) vq.push_back(mk(1,0,0,0,0, 0,0,1,2));
    vq.push_back(mk(1,0,0,0,0, 1,0,1,1));
    for (int i = 0; i < 3; i++) vq.push_back(mk(1,0,0,0,0, 0,0,1,1));
    vq.push_back(mk(1,0,0,0,0, 1,1,0,0));
    vq.push_back(mk(1,0,0,0,0, 0,0,0,0));
    vq.push_back(mk(1,1,0,0,1, 0,0,1,1));
    vq.push_back(mk(0,0,0,0,0, 0,0,1,1));
    for (int i = 0; i < 3; i++) vq.push_back(mk(1,0,0,0,0, 0,0,1,1));
    vq.push_back(mk(0,0,0,0,0, 0,0,1,1));
    vq.push_back(mk(1,0,0,0,0, 1,1,0,0));
    vq.push_back(mk(1,1,0,0,3, 0,0,1,3));
    for (int i = 0; i < 2; i++) vq.push_back(mk(1,0,0,0,0, 0,0,1,3));
    vq.push_back(mk(1,1,0,0,1, 0,0,1,1));
    for (int i = 0; i < 3; i++) vq.push_back(mk(1,0,0,0,0, 0,0,1,1));
    vq.push_back(mk(1,0,0,0,0, 1,1,0,0));
    vq.push_back(mk(1,1,0,0,1, 0,0,1,1));
    for (int i = 0; i < 3; i++) vq.push_back(mk(1,0,0,0,0, 0,0,1,1));
    vq.push_back(mk(1,1,0,0,2, 1,1,1,2));
    vq.push_back(mk(1,0,1,0,0, 0,0,0,0));
    vq.push_back(mk(1,1,0,1,1, 0,0,1,1));
    for (int i = 0; i < 3; i++) vq.push_back(mk(1,0,0,0,0, 0,0,1,1));
    vq.push_back(mk(1,1,0,1,2, 1,0,1,2));
    vq.push_back(mk(1,0,1,0,0, 0,0,0,0));
    foreach (vq[i]) begin
      step(vq[i].en, vq[i].st, vq[i].ab, vq[i].per, vq[i].ld);
      chk($sformatf("vec%0d_tick", i), tick, vq[i].tk);
      chk($sformatf("vec%0d_timeout", i), timeout, vq[i].to);
      chk($sformatf("vec%0d_busy", i), busy, vq[i].bz);
      chk($sformatf("vec%0d_rem", i), remaining, vq[i].rm);
    end

    // One-shot load 3: ticks at +4,+8,+12, timeout at +12 only.
    step(1,1,0,0,3);
    k = cyc; t_cnt = 0; t_first = -1; w_first = -1; w_at12 = -1;
    tk_off.delete(); to_off.delete();
    for (int i = 0; i < 16; i++) begin
      step(1,0,0,0,0);
      if (tick) tk_off.push_back(cyc - k);
      if (timeout) to_off.push_back(cyc - k);
`ifdef TIMER_WARN_EN
      if (warn && w_first < 0) w_first = cyc - k;
      if (cyc - k == 12) w_at12 = warn;
`endif
    end
    chk("os_tick_count", tk_off.size(), 3);
    chk("os_to_count", to_off.size(), 1);
    if (tk_off.size() == 3) begin
      chk("os_tick0", tk_off[0], 4);
      chk("os_tick1", tk_off[1], 8);
      chk("os_tick2", tk_off[2], 12);
    end
    if (to_off.size() == 1) chk("os_to_at", to_off[0], 12);
`ifdef TIMER_WARN_EN
    chk("warn_rise", w_first, 8);
    chk("warn_clear", w_at12, 0);
`endif

    // Periodic load 2: timeouts at +8,+16,+24, busy held until abort.
    step(1,1,0,1,2);
    k = cyc; to_off.delete();
    for (int i = 0; i < 26; i++) begin
      step(1,0,0,0,0);
      if (timeout) to_off.push_back(cyc - k);
    end
    chk("per_to_count", to_off.size(), 3);
    if (to_off.size() == 3) begin
      chk("per_to0", to_off[0], 8);
      chk("per_to1", to_off[1], 16);
      chk("per_to2", to_off[2], 24);
    end
    chk("per_busy", busy, 1);
    step(1,0,1,0,0);
    chk("per_abort_busy", busy, 0);

    // Pause for 5 cycles at +3: timeout moves from +8 to +13.
    step(1,1,0,0,2);
    k = cyc; to_off.delete();
    for (int i = 1; i <= 16; i++) begin
      step((i >= 3 && i <= 7) ? 1'b0 : 1'b1, 0, 0, 0, 0);
      if (timeout) to_off.push_back(cyc - k);
    end
    chk("pause_to_count", to_off.size(), 1);
    if (to_off.size() == 1) chk("pause_to_at", to_off[0], 13);

    // Abort mid-run: no timeout afterwards.
    step(1,1,0,0,2);
    k = cyc; t_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1, 0, (i == 6) ? 1'b1 : 1'b0, 0, 0);
      if (timeout) t_cnt++;
      if (i == 6) chk("abort_busy", busy, 0);
    end
    chk("abort_no_to", t_cnt, 0);

    // Reset held mid-run for 3 cycles, then no stale timeout.
    step(1,1,0,1,3);
    repeat (5) step(1,0,0,0,0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_rem", remaining, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("mrst_hold_busy", busy, 0);
      chk("mrst_hold_to", timeout, 0);
      chk("mrst_hold_tick", tick, 0);
      chk("mrst_hold_rem", remaining, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    t_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1,0,0,0,0);
      if (timeout) t_cnt++;
    end
    chk("mrst_no_to", t_cnt, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
           ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)),
           $urandom_range(0, 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
